xs3_dec_seq: RTL and testbench

XS3_DEC_SEQ -- requirements
Module: xs3_dec_seq

---
 rtl/xs3_pkg.sv | 17 +
 rtl/xs3_digit_dec.sv | 14 +
 rtl/xs3_dec_seq.sv | 108 ++++++++++
 tb/tb_xs3_dec_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xs3_pkg.sv
// Shared definitions for the excess-3 digit sequencer: code offset,
// invalid-code test and controller state encoding.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  function automatic logic xs3_invalid(input logic [3:0] code);
    return (code < XS3_OFFSET) || (code > XS3_MAX);
  endfunction

endpackage

// File: rtl/xs3_digit_dec.sv
// Combinational excess-3 to BCD decode of one digit; invalid codes
// decode to 0 and raise inv_o.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] xs3_i,
  output logic [3:0] bcd_o,
  output logic       inv_o
);

  assign inv_o = xs3_invalid(xs3_i);
  assign bcd_o = inv_o ? 4'd0 : (xs3_i - XS3_OFFSET);

endmodule

// File: rtl/xs3_dec_seq.sv
// Assembles excess-3 digits into right-aligned packed BCD words of up to
// NDIG digits. Define XS3_DEC_ERR_CNT_EN to add the saturating err_cnt output.
module xs3_dec_seq
  import xs3_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_xs3,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [3:0]        out_ndig,
`ifdef XS3_DEC_ERR_CNT_EN
  output logic              out_err,
  output logic [7:0]        err_cnt
`else
  output logic              out_err
`endif
);

  localparam int ACC_W = 4 * NDIG;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_base;
  logic [3:0]         cnt_q, cnt_d, cnt_base, cnt_inc;
  logic               err_q, err_d, err_base;
  logic               accept, fresh, word_end;
  logic [3:0]         dig_bcd;
  logic               dig_inv;

  xs3_digit_dec u_dec (
    .xs3_i (in_xs3),
    .bcd_o (dig_bcd),
    .inv_o (dig_inv)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    in_ready = (state_q == COLLECT) || out_ready;
    accept   = in_valid && in_ready;
    // An accept while holding starts a new word, so build from a cleared base.
    fresh    = (state_q == HOLD);
    acc_base = fresh ? '0 : acc_q;
    cnt_base = fresh ? 4'd0 : cnt_q;
    err_base = fresh ? 1'b0 : err_q;
    cnt_inc  = cnt_base + 4'd1;
    word_end = in_last || (cnt_inc == 4'(NDIG));

    if ((state_q == HOLD) && out_ready) begin
      state_d = COLLECT;
      acc_d   = '0;
      cnt_d   = 4'd0;
      err_d   = 1'b0;
    end

    if (accept) begin
      acc_d   = (acc_base << 4) | ACC_W'(dig_bcd);
      cnt_d   = cnt_inc;
      err_d   = err_base | dig_inv;
      state_d = word_end ? HOLD : COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_bcd   = acc_q;
  assign out_ndig  = cnt_q;
  assign out_err   = err_q;

`ifdef XS3_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && dig_inv && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_xs3_dec_seq.sv
// Scoreboard bench for xs3_dec_seq (NDIG=4); also builds with XS3_DEC_ERR_CNT_EN.
module tb_xs3_dec_seq;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_xs3;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_ndig;
  logic        out_err;
`ifdef XS3_DEC_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  xs3_dec_seq #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_xs3    (in_xs3),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ndig  (out_ndig),
`ifdef XS3_DEC_ERR_CNT_EN
    .out_err   (out_err),
    .err_cnt   (err_cnt)
`else
    .out_err   (out_err)
`endif
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  ndig;
    logic        err;
  } word_t;

  word_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] m_acc = 16'h0;
  int          m_n = 0;
  logic        m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 16'h0;
    m_n   = 0;
    m_err = 1'b0;
  endtask

  // Present one digit, wait for its accept edge, then update the reference model.
  task automatic send(input logic [3:0] code, input logic last);
    bit         done = 0;
    logic [3:0] dec;
    logic       bad;
    word_t      w;
    in_valid = 1'b1;
    in_xs3   = code;
    in_last  = last;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        done = 1;
      end
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      check("accept_timeout", 32'(done), 32'd1);
    end else begin
      bad   = (code < 4'd3) || (code > 4'd12);
      dec   = bad ? 4'd0 : code - 4'd3;
      m_acc = {m_acc[11:0], dec};
      m_n++;
      m_err = m_err | bad;
      if (last || m_n == NDIG) begin
        w.bcd  = m_acc;
        w.ndig = 4'(m_n);
        w.err  = m_err;
        sb_q.push_back(w);
        model_clear();
      end
    end
  endtask

  always @(negedge clk) begin
    word_t w;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        w = sb_q.pop_front();
        check("word_bcd", 32'(out_bcd), 32'(w.bcd));
        check("word_ndig", 32'(out_ndig), 32'(w.ndig));
        check("word_err", 32'(out_err), 32'(w.err));
      end
    end
  end

  initial begin
    int c0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_xs3    = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    check("rst_out_ndig", 32'(out_ndig), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain four-digit word
    send(4'b0100, 1'b0);
    send(4'b0101, 1'b0);
    send(4'b0110, 1'b0);
    check("w1_not_early", 32'(out_valid), 32'd0);
    send(4'b0111, 1'b0);
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_bcd", 32'(out_bcd), 32'h1234);
    check("w1_ndig", 32'(out_ndig), 32'd4);
    check("w1_err", 32'(out_err), 32'd0);

    // Invalid code in second position
    send(4'b0100, 1'b0);
    send(4'b1111, 1'b0);
    send(4'b0110, 1'b0);
    send(4'b0111, 1'b0);
    check("w2_bcd", 32'(out_bcd), 32'h1034);
    check("w2_err", 32'(out_err), 32'd1);
`ifdef XS3_DEC_ERR_CNT_EN
    check("w2_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Early termination with in_last
    send(4'b0100, 1'b0);
    send(4'b1100, 1'b1);
    check("w3_valid", 32'(out_valid), 32'd1);
    check("w3_bcd", 32'(out_bcd), 32'h0019);
    check("w3_ndig", 32'(out_ndig), 32'd2);

    // Backpressure on a completed word
    send(4'd7, 1'b0);
    send(4'd8, 1'b0);
    send(4'd9, 1'b0);
    out_ready = 1'b0;
    send(4'd10, 1'b0);
    in_valid = 1'b1;
    in_xs3   = 4'd3;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_bcd", 32'(out_bcd), 32'h4567);
      check("bp_ndig", 32'(out_ndig), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'd3, 1'b0);
    check("bp_next_collect", 32'(out_valid), 32'd0);
    check("bp_next_ndig", 32'(out_ndig), 32'd1);
    send(4'd3, 1'b0);
    send(4'd3, 1'b0);
    send(4'd4, 1'b0);
    check("bp_w2_bcd", 32'(out_bcd), 32'h0001);

    // Reset in the middle of a word
    send(4'd4, 1'b0);
    send(4'd5, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_clear();
    sb_q.delete();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bcd", 32'(out_bcd), 32'd0);
    check("mid_rst_ndig", 32'(out_ndig), 32'd0);
    check("mid_rst_err", 32'(out_err), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(4'd8, 1'b0);
    send(4'd9, 1'b0);
    send(4'd10, 1'b0);
    send(4'd11, 1'b0);
    check("post_rst_bcd", 32'(out_bcd), 32'h5678);
    check("post_rst_ndig", 32'(out_ndig), 32'd4);

    // Back-to-back streaming through the hold/accept overlap
    c0 = cyc;
    for (int d = 9; d >= 2; d--) send(4'(d + 3), 1'b0);
    check("stream_cycles", 32'(cyc - c0), 32'd8);
    check("stream_w2_bcd", 32'(out_bcd), 32'h5432);

    // Random digits and terminations
    for (int i = 0; i < 40; i++)
      send(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

    repeat (4) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
